// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: FSM encodings, owner codes and request bus width shared by the arbiter files
package cpu_mem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D} arb_state_e;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam int REQ_W = 1 + 32 + 32 + 4;
endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: downstream unified memory request/response bus
interface cpu_mem_arbiter_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );
  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/cpu_mem_arbiter_fifo.sv
// arb_owner_fifo: 1-bit sync FIFO recording which channel owns each outstanding read
module arb_owner_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0] mem;
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head  = mem[rp];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: fixed-priority (data over fetch) arbiter onto one memory port with in-order response routing.
// Optional macro ARB_PERF_CNT_EN enables the grant/conflict performance counters.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  cpu_mem_arbiter_if.master mem,
  output logic        arb_err,
  output logic [31:0] perf_inst_grant,
  output logic [31:0] perf_data_grant,
  output logic [31:0] perf_conflict
);
  localparam int OWN_W = $clog2(OUTSTANDING) + 1;
  arb_state_e state, nxt;
  logic d_req, i_req, rd_block, d_ok, i_ok, sel_d, sel_i, acc;
  logic push, pop, head, full, empty;
  logic [OWN_W-1:0] count;
  logic [REQ_W-1:0] req;
  assign d_req    = MemRead | MemWrite;
  assign i_req    = Inst_Req_Valid;
  assign rd_block = (count == OWN_W'(OUTSTANDING));
  assign d_ok     = d_req & ~(MemRead & rd_block);
  assign i_ok     = i_req & ~rd_block;
  always_ff @(posedge clk) state <= rst ? ARB_IDLE : nxt;
  always_comb begin
    sel_d = (state == ARB_LOCK_D) | ((state == ARB_IDLE) & d_ok);
    sel_i = (state == ARB_LOCK_I) | ((state == ARB_IDLE) & ~d_ok & i_ok);
    nxt   = state;
    if (acc) nxt = ARB_IDLE;
    else if (state == ARB_IDLE && mem.mem_req_valid) nxt = sel_d ? ARB_LOCK_D : ARB_LOCK_I;
  end
  assign req = sel_d ? {MemWrite, Address, Write_data, Write_strb} : {1'b0, PC, 32'h0, 4'h0};
  assign {mem.mem_req_wen, mem.mem_req_addr, mem.mem_req_wdata, mem.mem_req_wstrb} = req;
  assign mem.mem_req_valid = ~rst & (sel_d | sel_i);
  assign acc            = mem.mem_req_valid & mem.mem_req_ready;
  assign Mem_Req_Ready  = acc & sel_d;
  assign Inst_Req_Ready = acc & sel_i;
  assign push = Inst_Req_Ready | (Mem_Req_Ready & MemRead);
  arb_owner_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(sel_d),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  // An empty FIFO still accepts responses so a stray one cannot wedge the downstream
  assign mem.mem_resp_ready = ~rst & (empty | (head == OWN_DATA ? Read_data_Ready : Inst_Ready));
  assign Inst_Valid      = ~rst & mem.mem_resp_valid & ~empty & (head == OWN_INST);
  assign Read_data_Valid = ~rst & mem.mem_resp_valid & ~empty & (head == OWN_DATA);
  assign Instruction     = mem.mem_resp_data;
  assign Read_data       = mem.mem_resp_data;
  assign pop = mem.mem_resp_valid & mem.mem_resp_ready & ~empty;
  always_ff @(posedge clk) arb_err <= ~rst & (arb_err | (mem.mem_resp_valid & empty));
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_grant <= '0;
      perf_data_grant <= '0;
      perf_conflict <= '0;
    end else begin
      perf_inst_grant <= perf_inst_grant + 32'(Inst_Req_Ready);
      perf_data_grant <= perf_data_grant + 32'(Mem_Req_Ready);
      perf_conflict <= perf_conflict + 32'(d_req & i_req);
    end
  end
`else
  assign perf_inst_grant = '0;
  assign perf_data_grant = '0;
  assign perf_conflict   = '0;
`endif
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one unified memory port between the pipeline's instruction-fetch channel and its data (load/store) channel.
- Sits between the custom CPU core and the memory/AXI bridge.
- Grants requests by fixed priority, holds the downstream request stable until it is accepted, and routes read responses back in order through an owner FIFO.

Parameters:
- OUTSTANDING, 2, max accepted-but-unanswered reads; power of two, 1..8.
- OWN_W, $clog2(OUTSTANDING)+1, width of the occupancy counter (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- PC  in  32  instruction fetch address
- Inst_Req_Valid  in  1  fetch request valid
- Inst_Req_Ready  out  1  fetch request accepted
- Instruction  out  32  fetched word
- Inst_Valid  out  1  fetched word valid
- Inst_Ready  in  1  core accepts fetched word
- Address  in  32  data address
- MemWrite  in  1  store request valid
- MemRead  in  1  load request valid (never together with MemWrite)
- Write_data  in  32  store data
- Write_strb  in  4  store byte enables
- Mem_Req_Ready  out  1  data request accepted
- Read_data  out  32  load data
- Read_data_Valid  out  1  load data valid
- Read_data_Ready  in  1  core accepts load data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_req_wen  out  1  1 = write, 0 = read
- mem_req_addr  out  32  downstream address
- mem_req_wdata  out  32  downstream write data
- mem_req_wstrb  out  4  downstream byte enables
- mem_resp_valid  in  1  downstream read data valid
- mem_resp_ready  out  1  arbiter accepts read data
- mem_resp_data  in  32  downstream read data
- arb_err  out  1  sticky: response arrived with no read outstanding
- perf_inst_grant  out  32  accepted fetch requests
- perf_data_grant  out  32  accepted data requests
- perf_conflict  out  32  cycles where both requesters were valid

Behaviour:
- Reset values:
  - FSM = IDLE; owner FIFO empty; count = 0; arb_err = 0; perf counters = 0.
  - All ready/valid outputs are 0 during rst.
  - The downstream is reset by the same rst; no response may cross reset.
- Definitions:
  - d_req = MemRead | MemWrite; i_req = Inst_Req_Valid.
  - rd_block = (count == OUTSTANDING). Blocks new reads even if a pop occurs the same cycle.
  - d_ok = d_req & ~(MemRead & rd_block); i_ok = i_req & ~rd_block.
- FSM states: IDLE, LOCK_I, LOCK_D.
- IDLE: grant = D if d_ok, else I if i_ok, else none. Data has priority because it is the older instruction.
  - The granted channel's fields drive mem_req_* combinationally, with mem_req_valid = 1. Fetch uses wen = 0 and wstrb = 0.
  - If mem_req_ready: the request is accepted in 0 cycles; the requester's ready pulses; the FSM stays in IDLE.
  - Else: the FSM goes to LOCK_D or LOCK_I.
- LOCK_x: only the locked channel is forwarded, with mem_req_valid held at 1.
  - On mem_req_ready: the requester's ready pulses; the FSM returns to IDLE.
  - The other channel sees ready = 0 throughout.
  - Requesters must hold their request stable until ready; the arbiter never withdraws a valid request.
- Owner FIFO (1 bit per entry: 0 = inst, 1 = data):
  - Push on every accepted read (all fetches and MemRead).
  - Pop on mem_resp_valid & mem_resp_ready.
  - Push and pop in the same cycle keeps count unchanged. Pointers wrap modulo OUTSTANDING.
  - Writes never push and never produce a response.
- Response routing (head = FIFO head):
  - head = 0: Instruction = mem_resp_data, Inst_Valid = mem_resp_valid, mem_resp_ready = Inst_Ready.
  - head = 1: Read_data = mem_resp_data, Read_data_Valid = mem_resp_valid, mem_resp_ready = Read_data_Ready.
  - The non-selected valid is 0. Response latency through the arbiter is 0 cycles.
- FIFO empty with mem_resp_valid: mem_resp_ready = 1 (response dropped), arb_err sets and stays set until rst. No valid is forwarded.
- Ordering: the downstream returns read data in acceptance order. A write accepted after a read may complete before that read returns.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters.
  - perf_inst_grant increments on each accepted fetch.
  - perf_data_grant increments on each accepted load/store.
  - perf_conflict increments each cycle d_req & i_req.
- Undefined: the counters are not instantiated; the three ports are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package/header (mycpu.h style):
  - FSM state encodings ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D.
  - Owner codes OWN_INST = 1'b0, OWN_DATA = 1'b1.
  - Request bus width macro for {wen, addr, wdata, wstrb}.
- One sub-module: arb_owner_fifo, a parameterised 1-bit sync FIFO with push, pop, head, full, empty and count.

Test Plan:
- Simultaneous fetch PC=0x100 and MemRead Address=0x2000, mem_req_ready=1 -> data granted first (addr 0x2000). Fetch granted next cycle. Responses 0xAAAA then 0xBBBB arrive as Read_data=0xAAAA, then Instruction=0xBBBB.
- Store Address=0x40, Write_data=0xDEADBEEF, Write_strb=4'b0011, mem_req_ready low for 3 cycles -> mem_req_* stable for 4 cycles. Fetch stalled with Inst_Req_Ready=0. No FIFO push, no response expected.
- OUTSTANDING=2, two fetches accepted, no responses -> third fetch and a MemRead see ready=0. A concurrent MemWrite is still accepted. After one response, the next read is accepted the following cycle.
- Response with Inst_Ready=0 for 2 cycles -> mem_resp_ready=0 and FIFO head unchanged. On the third cycle the pop occurs and count decrements.
- mem_resp_valid=1 with empty FIFO -> mem_resp_ready=1, arb_err=1 and held. rst clears it to 0.
- rst asserted while in LOCK_D with 2 reads outstanding -> next cycle FSM=IDLE, count=0, all readies 0. With ARB_PERF_CNT_EN, counters read 0.
